// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL_REQ,
    ST_REFILL_WAIT
  } cache_state_e;

  function automatic int tag_width(input int addr_w, input int set_w);
    return addr_w - set_w;
  endfunction

  function automatic int way_count(input int way_w);
    return 1 << way_w;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// Per-set age-based LRU: age 0 is most recent, age WAYS-1 is the victim.
module lru_tracker
  import cache_pkg::*;
#(
  parameter int SET_BIT_WIDTH = 2,
  parameter int WAY_BIT_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SET_BIT_WIDTH-1:0] set_idx,
  input  logic [WAY_BIT_WIDTH-1:0] access_way,
  input  logic                     access_en,
  output logic [WAY_BIT_WIDTH-1:0] victim_way
);

  localparam int SETS = 1 << SET_BIT_WIDTH;
  localparam int WAYS = way_count(WAY_BIT_WIDTH);

  logic [WAY_BIT_WIDTH-1:0] age_q [SETS][WAYS];

  // Ages younger than the accessed way grow older; accessed way becomes age 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_BIT_WIDTH'(w);
    end else if (access_en) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[set_idx][w] < age_q[set_idx][access_way])
          age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
      age_q[set_idx][access_way] <= '0;
    end
  end

  // The oldest way of the selected set is the replacement candidate.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[set_idx][w] == WAY_BIT_WIDTH'(WAYS - 1))
        victim_way = WAY_BIT_WIDTH'(w);
  end

endmodule

// File: rtl/set_associative_cache.sv
// N-way set-associative write-back/write-allocate cache with blocking miss FSM.
module set_associative_cache
  import cache_pkg::*;
#(
  parameter int SET_BIT_WIDTH = 2,
  parameter int WAY_BIT_WIDTH = 1,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

  localparam int SETS  = 1 << SET_BIT_WIDTH;
  localparam int WAYS  = way_count(WAY_BIT_WIDTH);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SET_BIT_WIDTH);

  cache_state_e state_q, state_d;

  logic                     miss_q;
  logic                     write_q;
  logic [WAY_BIT_WIDTH-1:0] victim_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  logic [SET_BIT_WIDTH-1:0] set_idx;
  logic [TAG_W-1:0]         tag_in;
  logic                     hit;
  logic [WAY_BIT_WIDTH-1:0] hit_way;
  logic [WAY_BIT_WIDTH-1:0] lru_victim;
  logic [WAY_BIT_WIDTH-1:0] victim_d;
  logic                     lru_access;

  assign set_idx    = addr_q[SET_BIT_WIDTH-1:0];
  assign tag_in     = addr_q[ADDR_WIDTH-1:SET_BIT_WIDTH];
  assign lru_access = (state_q == ST_LOOKUP) && hit;

  lru_tracker #(
    .SET_BIT_WIDTH(SET_BIT_WIDTH),
    .WAY_BIT_WIDTH(WAY_BIT_WIDTH)
  ) u_lru (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (set_idx),
    .access_way(hit_way),
    .access_en (lru_access),
    .victim_way(lru_victim)
  );

  // Parallel tag compare across all ways of the latched set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_BIT_WIDTH'(w);
      end
  end

  // Victim: lowest-index invalid way, falling back to the LRU way.
  always_comb begin
    victim_d = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[set_idx][w])
        victim_d = WAY_BIT_WIDTH'(w);
  end

  // Next-state and all interface outputs.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = !miss_q;
          resp_rdata = write_q ? wdata_q : data_q[set_idx][hit_way];
          state_d    = ST_IDLE;
        end else if (valid_q[set_idx][victim_d] && dirty_q[set_idx][victim_d]) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_REFILL_REQ;
        end
      end
      ST_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[set_idx][victim_q], set_idx};
        mem_req_wdata = data_q[set_idx][victim_q];
        if (mem_req_ready) state_d = ST_REFILL_REQ;
      end
      ST_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_d = ST_REFILL_WAIT;
      end
      ST_REFILL_WAIT: begin
        if (mem_resp_valid) state_d = ST_LOOKUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, miss flag, victim choice, valid/dirty bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      miss_q   <= 1'b0;
      write_q  <= 1'b0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        write_q <= req_write;
        miss_q  <= 1'b0;
      end
      if (state_q == ST_LOOKUP) begin
        if (hit && write_q) dirty_q[set_idx][hit_way] <= 1'b1;
        if (!hit) begin
          miss_q   <= 1'b1;
          victim_q <= victim_d;
        end
      end
      if (state_q == ST_WRITEBACK && mem_req_ready)
        dirty_q[set_idx][victim_q] <= 1'b0;
      if (state_q == ST_REFILL_WAIT && mem_resp_valid) begin
        valid_q[set_idx][victim_q] <= 1'b1;
        dirty_q[set_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Datapath storage: request latch, line tags and data.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state_q == ST_LOOKUP && hit && write_q)
      data_q[set_idx][hit_way] <= wdata_q;
    if (state_q == ST_REFILL_WAIT && mem_resp_valid) begin
      tag_q[set_idx][victim_q]  <= tag_in;
      data_q[set_idx][victim_q] <= mem_resp_rdata;
    end
  end

endmodule
